// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//
// Shares one ALU among NREQ requesters. Each operation is accepted from one
// requester at a time by round-robin arbitration. The scheduler drives the ALU
// for the command-dependent latency, captures the result and flags, and returns
// them with the requester index over a valid/ready response channel. Only one
// operation is in flight at a time.
//
// Ports
//   CLK, RST            clock (rising edge); asynchronous active-low reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot or zero
//   req_opa/req_opb     packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cmd             packed commands, requester i at [i*CMD_W +: CMD_W]
//   req_mode/req_cin    per-requester mode (1=arithmetic) and carry in
//   alu_*  (out)        operands and control pins driven to the ALU
//   alu_res, flags (in) ALU result and status flags
//   rsp_valid/ready     response handshake
//   rsp_id/res/flags    requester index, captured result, {cout,oflow,g,l,e,err}
//   busy                high whenever an operation is in progress
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int CMD_W   = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*WIDTH-1:0]         req_opa,
  input  logic [NREQ*WIDTH-1:0]         req_opb,
  input  logic [NREQ*CMD_W-1:0]         req_cmd,
  input  logic [NREQ-1:0]               req_mode,
  input  logic [NREQ-1:0]               req_cin,
  output logic [WIDTH-1:0]              alu_opa,
  output logic [WIDTH-1:0]              alu_opb,
  output logic [CMD_W-1:0]              alu_cmd,
  output logic                          alu_mode,
  output logic                          alu_cin,
  output logic                          alu_ce,
  output logic [1:0]                    alu_inp_valid,
  input  logic [2*WIDTH-1:0]            alu_res,
  input  logic                          alu_cout,
  input  logic                          alu_oflow,
  input  logic                          alu_g,
  input  logic                          alu_l,
  input  logic                          alu_e,
  input  logic                          alu_err,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [2*WIDTH-1:0]            rsp_res,
  output logic [5:0]                    rsp_flags,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int MAXL  = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int CNT_W = $clog2(MAXL + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_id;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [CMD_W-1:0]   r_cmd;
  logic               r_mode;
  logic               r_cin;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_res;
  logic [5:0]         r_flags;

  // Unpacked views of the packed request buses
  logic [WIDTH-1:0]   w_opa_arr [NREQ];
  logic [WIDTH-1:0]   w_opb_arr [NREQ];
  logic [CMD_W-1:0]   w_cmd_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_opa_arr[gi] = req_opa[gi*WIDTH +: WIDTH];
      assign w_opb_arr[gi] = req_opb[gi*WIDTH +: WIDTH];
      assign w_cmd_arr[gi] = req_cmd[gi*CMD_W +: CMD_W];
    end
  endgenerate

  // Round-robin search starting one past the last grant, wrapping at NREQ.
  // The sum needs one extra bit before the wrap subtraction.
  logic              w_gnt_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W:0]     w_idx;

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_last} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NREQ)) begin
        w_idx = w_idx - (ID_W+1)'(NREQ);
      end
      if (!w_gnt_found && req_valid[w_idx[ID_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_idx[ID_W-1:0];
      end
    end
  end

  // Multiply commands take the longer ALU path
  logic w_is_mul;
  assign w_is_mul = r_mode && ((r_cmd == CMD_W'(9)) || (r_cmd == CMD_W'(10)));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_found)      w_state_next = S_ISSUE;
      S_ISSUE:                       w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == CNT_W'(1)) w_state_next = S_RESP;
      S_RESP:  if (rsp_ready)        w_state_next = S_IDLE;
      default:                       w_state_next = S_IDLE;
    endcase
  end

  // Grant is combinational in IDLE only; gated by RST so nothing is accepted
  // while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (RST && (r_state == S_IDLE) && w_gnt_found) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_last  <= ID_W'(NREQ - 1);
      r_id    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_cmd   <= '0;
      r_mode  <= 1'b0;
      r_cin   <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_opa  <= w_opa_arr[w_gnt_idx];
            r_opb  <= w_opb_arr[w_gnt_idx];
            r_cmd  <= w_cmd_arr[w_gnt_idx];
            r_mode <= req_mode[w_gnt_idx];
            r_cin  <= req_cin[w_gnt_idx];
            r_id   <= w_gnt_idx;
            r_last <= w_gnt_idx;
          end
        end
        S_ISSUE: begin
          r_cnt <= w_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Last wait cycle: the ALU result is valid now
          if (r_cnt == CNT_W'(1)) begin
            r_res   <= alu_res;
            r_flags <= {alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err};
          end
        end
        default: ;
      endcase
    end
  end

  logic w_alu_active;
  assign w_alu_active  = (r_state == S_ISSUE) || (r_state == S_WAIT);

  assign alu_opa       = r_opa;
  assign alu_opb       = r_opb;
  assign alu_cmd       = r_cmd;
  assign alu_mode      = r_mode;
  assign alu_cin       = r_cin;
  assign alu_ce        = w_alu_active;
  assign alu_inp_valid = {2{w_alu_active}};

  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_id        = r_id;
  assign rsp_res       = r_res;
  assign rsp_flags     = r_flags;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_scheduler
//
// Self-checking bench for alu_rr_scheduler with a small behavioural ALU whose
// result appears LAT (or MUL_LAT for multiplies) edges after issue. Expected
// responses are queued when requests are driven and compared on handshake.
// -----------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CW   = 4;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_opa;
  logic [NREQ*W-1:0] req_opb;
  logic [NREQ*CW-1:0] req_cmd;
  logic [NREQ-1:0]   req_mode;
  logic [NREQ-1:0]   req_cin;
  logic [W-1:0]      alu_opa;
  logic [W-1:0]      alu_opb;
  logic [CW-1:0]     alu_cmd;
  logic              alu_mode;
  logic              alu_cin;
  logic              alu_ce;
  logic [1:0]        alu_inp_valid;
  logic [2*W-1:0]    alu_res;
  logic              alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*W-1:0]    rsp_res;
  logic [5:0]        rsp_flags;
  logic              busy;

  alu_rr_scheduler #(.NREQ(NREQ), .WIDTH(W), .CMD_W(CW), .LAT(1), .MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_ce(alu_ce),
    .alu_inp_valid(alu_inp_valid), .alu_res(alu_res),
    .alu_cout(alu_cout), .alu_oflow(alu_oflow), .alu_g(alu_g),
    .alu_l(alu_l), .alu_e(alu_e), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural ALU: returns {res[15:0], cout, oflow, g, l, e, err}
  function automatic logic [21:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] c, input logic m, input logic ci);
    logic [15:0] r;
    logic [8:0]  s;
    logic        co, of, er;
    r = '0; s = '0; co = 1'b0; of = 1'b0; er = 1'b0;
    if (m) begin
      case (c)
        4'd0: begin s = {1'b0, a} + {1'b0, b}; r = {7'd0, s}; co = s[8];
                    of = (a[7] == b[7]) && (s[7] != a[7]); end
        4'd2: begin s = {1'b0, a} + {1'b0, b} + {8'd0, ci}; r = {7'd0, s}; co = s[8];
                    of = (a[7] == b[7]) && (s[7] != a[7]); end
        4'd9:  r = {8'd0, a} * {8'd0, b};
        4'd10: r = ({8'd0, a} << 1) * {8'd0, b};
        default: er = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0: r = {8'd0, a & b};
        4'd1: r = {8'd0, a | b};
        4'd2: r = {8'd0, a ^ b};
        default: er = 1'b1;
      endcase
    end
    return {r, co, of, (a > b), (a < b), (a == b), er};
  endfunction

  // ALU timing model: while issued, the first edge yields the result for
  // ordinary commands; multiplies show junk on the first edge, result on the
  // second. Early sampling by the scheduler therefore captures junk.
  logic [15:0] m_res;
  logic [5:0]  m_fl;
  logic [3:0]  m_cnt;
  logic [21:0] m_val;
  logic        m_mul;
  assign m_val = alu_f(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin);
  assign m_mul = alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10);

  always @(posedge CLK) begin
    if (alu_ce && alu_inp_valid == 2'b11) begin
      m_cnt <= m_cnt + 4'd1;
      if (m_mul && m_cnt == 4'd0) begin
        m_res <= 16'hDEAD;
        m_fl  <= 6'b101010;
      end else begin
        m_res <= m_val[21:6];
        m_fl  <= m_val[5:0];
      end
    end else begin
      m_cnt <= 4'd0;
      m_res <= 16'hFFFF;
      m_fl  <= 6'b010101;
    end
  end

  assign alu_res = m_res;
  assign {alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err} = m_fl;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
    logic [5:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, input logic m, input logic ci, input bit push);
    logic [21:0] f;
    exp_t        e;
    req_opa[i*W +: W]   = a;
    req_opb[i*W +: W]   = b;
    req_cmd[i*CW +: CW] = c;
    req_mode[i]         = m;
    req_cin[i]          = ci;
    req_valid[i]        = 1'b1;
    if (push) begin
      f     = alu_f(a, b, c, m, ci);
      e.id  = 2'(i);
      e.res = f[21:6];
      e.fl  = f[5:0];
      sb.push_back(e);
    end
  endtask

  // Waits for a grant; the requester drops req_valid right after the accepting edge.
  // Returns just after the edge that enters ISSUE.
  task automatic wait_grant(output int g);
    g = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (|(req_valid & req_ready)) begin
        chk("gnt_onehot", 64'($onehot(req_ready)), 64'd1);
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        break;
      end
    end
    if (g < 0) begin
      chk("gnt_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge CLK);
      #1;
      req_valid[g] = 1'b0;
    end
  endtask

  // Counts cycles from ISSUE until rsp_valid, and cycles with the ALU issued.
  task automatic wait_rsp(output int lat, output int ivc);
    lat = 0;
    ivc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      lat++;
      if (alu_ce && alu_inp_valid == 2'b11) ivc++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  // Called at a negedge with rsp_valid high: compare against the scoreboard,
  // complete the handshake, and confirm return to IDLE on the next edge.
  task automatic take_rsp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected", 64'(rsp_id), 64'hFF);
    end else begin
      e = sb.pop_front();
      chk("rsp_id", 64'(rsp_id), 64'(e.id));
      chk("rsp_res", 64'(rsp_res), 64'(e.res));
      chk("rsp_flags", 64'(rsp_flags), 64'(e.fl));
      $display("rsp id=%0d res=%04h flags=%06b", rsp_id, rsp_res, rsp_flags);
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("rsp_drop", {62'd0, rsp_valid, busy}, 64'd0);
  endtask

  int g, lat, ivc, lat_add;
  logic [23:0] hold;

  initial begin
    RST       = 1'b0;
    req_valid = '0;
    req_opa   = '0;
    req_opb   = '0;
    req_cmd   = '0;
    req_mode  = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_out", 64'({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid,
                        rsp_valid, rsp_id, rsp_res, rsp_flags, busy, req_ready}), 64'd0);

    // All four valid at reset release: expect grants 0,1,2,3,0
    set_req(0, 8'h10, 8'h20, 4'd0, 1'b1, 1'b0, 1'b1);
    set_req(1, 8'hF0, 8'h3C, 4'd0, 1'b0, 1'b0, 1'b1);
    set_req(2, 8'hA5, 8'h5A, 4'd2, 1'b0, 1'b0, 1'b1);
    set_req(3, 8'hFF, 8'h01, 4'd2, 1'b1, 1'b1, 1'b1);
    @(negedge CLK);
    chk("rst_noready", 64'(req_ready), 64'd0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_order", 64'(g), 64'(k % 4));
      if (k == 0) set_req(0, 8'h7F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b1);
      wait_rsp(lat, ivc);
      take_rsp();
    end

    // Single ADD: 0F + 01
    set_req(0, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b1);
    wait_grant(g);
    chk("add_gnt", 64'(g), 64'd0);
    wait_rsp(lat_add, ivc);
    chk("add_lat", 64'(lat_add), 64'd3);
    chk("add_ivc", 64'(ivc), 64'd2);
    chk("add_res", 64'(rsp_res), 64'h0010);
    chk("add_co_of", 64'(rsp_flags[5:4]), 64'd0);
    take_rsp();

    // Multiply: one cycle longer than ADD
    set_req(2, 8'd3, 8'd4, 4'd9, 1'b1, 1'b0, 1'b1);
    wait_grant(g);
    chk("mul_gnt", 64'(g), 64'd2);
    wait_rsp(lat, ivc);
    chk("mul_lat_delta", 64'(lat - lat_add), 64'd1);
    chk("mul_ivc", 64'(ivc), 64'd3);
    chk("mul_res", 64'(rsp_res), 64'd12);
    take_rsp();

    // Backpressure: hold response for 10 cycles while another request waits
    rsp_ready = 1'b0;
    set_req(1, 8'h80, 8'h80, 4'd0, 1'b1, 1'b0, 1'b1);
    wait_grant(g);
    chk("bp_gnt", 64'(g), 64'd1);
    set_req(3, 8'h55, 8'h0F, 4'd1, 1'b0, 1'b0, 1'b1);
    wait_rsp(lat, ivc);
    hold = {rsp_id, rsp_res, rsp_flags};
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      chk("bp_hold", 64'({rsp_valid, rsp_id, rsp_res, rsp_flags}), 64'({1'b1, hold}));
      chk("bp_noready", 64'(req_ready), 64'd0);
      chk("bp_noce", 64'({alu_ce, alu_inp_valid}), 64'd0);
    end
    take_rsp();
    wait_grant(g);
    chk("bp_next_gnt", 64'(g), 64'd3);
    wait_rsp(lat, ivc);
    take_rsp();

    // Error passthrough
    set_req(1, 8'h12, 8'h34, 4'd15, 1'b1, 1'b0, 1'b1);
    wait_grant(g);
    wait_rsp(lat, ivc);
    chk("err_flag", 64'(rsp_flags[0]), 64'd1);
    chk("err_id", 64'(rsp_id), 64'd1);
    take_rsp();

    // Reset during WAIT: operation aborted, pointer back to requester 0
    set_req(1, 8'd7, 8'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    wait_grant(g);
    @(posedge CLK);
    #3;
    chk("pre_rst_wait", 64'({busy, alu_ce}), 64'd3);
    RST = 1'b0;
    #1;
    chk("rst_async", 64'({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid,
                          rsp_valid, rsp_id, rsp_res, rsp_flags, busy, req_ready}), 64'd0);
    set_req(2, 8'h21, 8'h12, 4'd0, 1'b1, 1'b0, 1'b0);
    set_req(0, 8'h01, 8'h02, 4'd0, 1'b1, 1'b0, 1'b1);
    begin
      exp_t e;
      logic [21:0] f;
      f = alu_f(8'h21, 8'h12, 4'd0, 1'b1, 1'b0);
      e.id = 2'd2; e.res = f[21:6]; e.fl = f[5:0];
      sb.push_back(e);
    end
    @(negedge CLK);
    chk("rst_hold_noready", 64'(req_ready), 64'd0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    wait_grant(g);
    chk("post_rst_gnt", 64'(g), 64'd0);
    wait_rsp(lat, ivc);
    take_rsp();
    wait_grant(g);
    chk("post_rst_gnt2", 64'(g), 64'd2);
    wait_rsp(lat, ivc);
    take_rsp();

    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares one ALU_DESIGN instance among NREQ requesters. It accepts one operation at a time, drives the ALU operand/command/control pins, and waits the command-dependent ALU latency. It then captures RES and flags and returns them with the requester ID over a valid/ready response channel. It sits between the requester-side agents and the ALU inside the ALU subsystem top.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand width (OPA/OPB)
CMD_W, 4, command width
LAT, 1, ALU result latency in cycles after the issue edge, non-multiply commands
MUL_LAT, 2, ALU result latency for multiply commands (MODE=1, CMD=9 or 10)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_opa  in  NREQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
req_opb  in  NREQ*WIDTH  packed operand B
req_cmd  in  NREQ*CMD_W  packed command
req_mode  in  NREQ  1=arithmetic, 0=logical
req_cin  in  NREQ  carry in
alu_opa/alu_opb  out  WIDTH  to ALU OPA/OPB
alu_cmd  out  CMD_W  to ALU CMD
alu_mode, alu_cin, alu_ce  out  1  to ALU MODE/CIN/CE
alu_inp_valid  out  2  to ALU INP_VALID
alu_res  in  2*WIDTH  ALU RES
alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err  in  1  ALU flags
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NREQ)  requester index of the response
rsp_res  out  2*WIDTH  captured result
rsp_flags  out  6  {cout,oflow,g,l,e,err} captured
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; all alu_* outputs, rsp_*, req_ready and busy are 0. Last-grant pointer = NREQ-1, so requester 0 has first priority. Reset during any state aborts the operation; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_valid is set:
  - Grant g is the first set bit searching from (last+1) mod NREQ upward, with wrap-around.
  - req_ready[g]=1 combinationally in that cycle only.
  - On the clock edge: latch requester g's opa/opb/cmd/mode/cin and id; last=g; go to ISSUE.
  - With no req_valid, stay in IDLE with req_ready=0.
- ISSUE (1 cycle):
  - Drive latched operands and control; alu_inp_valid=2'b11; alu_ce=1.
  - Load the wait counter with MUL_LAT if mode=1 and cmd is 9 or 10, else LAT; go to WAIT.
- WAIT:
  - alu_* outputs are held stable at their ISSUE values; alu_ce=1, alu_inp_valid=2'b11.
  - The counter decrements each cycle.
  - In the cycle where counter==1: capture alu_res and the flags into rsp_res/rsp_flags, then go to RESP.
  - Net timing: the result is sampled at the end of cycle ISSUE+L, where L is the selected latency.
- RESP:
  - rsp_valid=1; rsp_id, rsp_res and rsp_flags are held stable.
  - alu_ce=0 and alu_inp_valid=2'b00 from RESP entry.
  - On rsp_valid&&rsp_ready: go to IDLE and clear rsp_valid on the next edge.
  - No new grant is issued while in RESP; the scheduler handles one operation in flight, with no pipelining.
- Throughput without backpressure: one operation per (3+L) cycles.
- Fairness:
  - A requester holding req_valid is granted within NREQ operations.
  - Requesters must hold req_valid and their operands stable until they see req_ready; a deasserted req_valid is never granted.
- Simultaneous requests: exactly one grant per IDLE visit; all other requesters keep waiting.
- alu_err is passed through in rsp_flags[0] unchanged; the scheduler does not retry.
- Widths: alu_res is captured as-is (2*WIDTH); no truncation.

Test Plan:
- Single request: req0 ADD (mode=1, cmd=0) opa=8'h0F, opb=8'h01, cin=0 -> ALU sees inp_valid=2'b11 for 1+LAT cycles. Then rsp_valid=1, rsp_id=0, rsp_res=16'h0010, flags cout=0/oflow=0.
- All four requesters valid at reset release -> grant order 0,1,2,3,0 across five operations. req_ready is one-hot each grant; rsp_id sequence matches.
- Multiply: req2 mode=1 cmd=9 with opa=3, opb=4 -> rsp_valid asserts exactly 1 cycle later than for ADD, with MUL_LAT=2 versus LAT=1. rsp_res equals the ALU_DESIGN output for cmd 9 with these operands, captured unchanged.
- Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_id and rsp_res stay constant, req_ready stays 0 and no alu_ce pulse occurs. Releasing rsp_ready -> return to IDLE next cycle.
- Reset mid-WAIT: drive RST=0 during WAIT -> all outputs 0 immediately with no edge needed, and no response after RST=1. The next grant goes to requester 0.
- Error passthrough: req1 issues a command for which the ALU asserts ERR=1 -> rsp_flags[0]=1 and rsp_id=1.
